// File: rtl/call_return_ctrl_if.sv
// ---------------------------------------------------------------------------
// call_return_ctrl_if
// Bundle between the program-counter side (master) and the call/return
// sequencer (slave).
//   master drives : instruction_address, call_req, ret_req, jump_req,
//                   target_address
//   slave drives  : jump_code, jump_address, return_address, stack_count,
//                   fault, fault_cause
// ---------------------------------------------------------------------------
interface call_return_ctrl_if #(
   parameter int INSTR_ADDR_SIZE = 5,
   parameter int STACK_DEPTH     = 4,
   parameter int CNT_W           = $clog2(STACK_DEPTH + 1)
);
   logic [INSTR_ADDR_SIZE-1:0] instruction_address;
   logic                       call_req;
   logic                       ret_req;
   logic                       jump_req;
   logic [INSTR_ADDR_SIZE-1:0] target_address;

   logic [4:0]                 jump_code;
   logic [INSTR_ADDR_SIZE-1:0] jump_address;
   logic [INSTR_ADDR_SIZE-1:0] return_address;
   logic [CNT_W-1:0]           stack_count;
   logic                       fault;
   logic [1:0]                 fault_cause;

   modport master (
      output instruction_address, call_req, ret_req, jump_req, target_address,
      input  jump_code, jump_address, return_address, stack_count, fault,
             fault_cause
   );

   modport slave (
      input  instruction_address, call_req, ret_req, jump_req, target_address,
      output jump_code, jump_address, return_address, stack_count, fault,
             fault_cause
   );
endinterface

// File: rtl/call_return_ctrl.sv
// ---------------------------------------------------------------------------
// call_return_ctrl
// Control-flow sequencer for the program counter. Issues a PC opcode every
// cycle (0 RESET, 1 JUMP, 2 RET, 3 DEFAULT/increment) and keeps a hardware
// return-address stack: CALL pushes PC+1 and jumps, RET pops, JUMP branches.
// Overflow or underflow enters a sticky FAULT state that holds the PC in
// RESET until RST.
// Ports:
//   CLK  - rising-edge clock
//   RST  - synchronous active-high reset
//   bus  - call_return_ctrl_if.slave (requests in, PC controls/status out)
// ---------------------------------------------------------------------------
module call_return_ctrl #(
   parameter int INSTR_ADDR_SIZE = 5,
   parameter int STACK_DEPTH     = 4,
   parameter int CNT_W           = $clog2(STACK_DEPTH + 1)
) (
   input logic                CLK,
   input logic                RST,
   call_return_ctrl_if.slave  bus
);

   localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

   localparam logic [4:0] JC_RESET   = 5'd0;
   localparam logic [4:0] JC_JUMP    = 5'd1;
   localparam logic [4:0] JC_RET     = 5'd2;
   localparam logic [4:0] JC_DEFAULT = 5'd3;

   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(STACK_DEPTH);
   localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

   typedef enum logic {ST_RUN, ST_FAULT} state_t;

   state_t                     state_reg, state_next;
   logic [CNT_W-1:0]           count_reg, count_next;
   logic [1:0]                 cause_reg, cause_next;
   logic [4:0]                 code_next;
   logic                       push_en;
   logic [INSTR_ADDR_SIZE-1:0] push_data;
   logic [IDX_W-1:0]           wr_idx;
   logic [IDX_W-1:0]           top_idx;

   logic [INSTR_ADDR_SIZE-1:0] stack_mem [STACK_DEPTH];

   // Return address wraps naturally at the address width.
   assign push_data = bus.instruction_address + INSTR_ADDR_SIZE'(1);
   // A push only happens below full, so the count always fits the index.
   assign wr_idx    = IDX_W'(count_reg);
   assign top_idx   = IDX_W'(count_reg - ONE_C);

   // -----------------------------------------------------------------------
   // Next-state and opcode decode
   // -----------------------------------------------------------------------
   always_comb begin
      state_next = state_reg;
      count_next = count_reg;
      cause_next = cause_reg;
      code_next  = JC_DEFAULT;
      push_en    = 1'b0;

      if (RST) begin
         // PC held in RESET for the whole reset cycle; registers clear at the edge.
         code_next = JC_RESET;
      end else begin
         unique case (state_reg)
            ST_RUN: begin
               if (bus.ret_req) begin
                  if (count_reg != '0) begin
                     code_next  = JC_RET;
                     count_next = count_reg - ONE_C;
                  end else begin
                     code_next  = JC_RESET;
                     state_next = ST_FAULT;
                     cause_next = 2'b10;
                     count_next = '0;
                  end
               end else if (bus.call_req) begin
                  if (count_reg < DEPTH_C) begin
                     code_next  = JC_JUMP;
                     push_en    = 1'b1;
                     count_next = count_reg + ONE_C;
                  end else begin
                     code_next  = JC_RESET;
                     state_next = ST_FAULT;
                     cause_next = 2'b01;
                     count_next = '0;
                  end
               end else if (bus.jump_req) begin
                  code_next = JC_JUMP;
               end
            end
            ST_FAULT: begin
               code_next  = JC_RESET;
               count_next = '0;
            end
            default: begin
               code_next = JC_RESET;
            end
         endcase
      end
   end

   // -----------------------------------------------------------------------
   // State registers
   // -----------------------------------------------------------------------
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_reg <= ST_RUN;
         count_reg <= '0;
         cause_reg <= 2'b00;
      end else begin
         state_reg <= state_next;
         count_reg <= count_next;
         cause_reg <= cause_next;
      end
   end

   // Stack storage: contents are don't-care after reset, so no reset term.
   always_ff @(posedge CLK) begin
      if (push_en) begin
         stack_mem[wr_idx] <= push_data;
      end
   end

   // -----------------------------------------------------------------------
   // Outputs
   // -----------------------------------------------------------------------
   assign bus.jump_code      = code_next;
   assign bus.jump_address   = bus.target_address;
   assign bus.return_address = (count_reg != '0) ? stack_mem[top_idx] : '0;
   assign bus.stack_count    = count_reg;
   assign bus.fault          = (state_reg == ST_FAULT);
   assign bus.fault_cause    = cause_reg;

endmodule

// File: tb/tb_call_return_ctrl.sv
// ---------------------------------------------------------------------------
// tb_call_return_ctrl
// Directed bench for call_return_ctrl: reset, call/return, nesting,
// overflow and underflow faults, request priority, address wrap and reset
// in the middle of a nest.
// ---------------------------------------------------------------------------
module tb_call_return_ctrl;

   logic CLK;
   logic RST;

   int vectors    = 0;
   int miscompares = 0;

   call_return_ctrl_if #(.INSTR_ADDR_SIZE(5), .STACK_DEPTH(4)) bus ();

   call_return_ctrl #(.INSTR_ADDR_SIZE(5), .STACK_DEPTH(4)) dut (
      .CLK (CLK),
      .RST (RST),
      .bus (bus.slave)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   task automatic chk(input string tag, input logic [7:0] obs,
                      input logic [7:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
      $display("check %-14s observed=%0d expected=%0d", tag, obs, exp);
   endtask

   // Drive one request set, then settle before sampling combinational outputs.
   task automatic drive(input logic c, input logic r, input logic j,
                        input logic [4:0] pc, input logic [4:0] tgt);
      bus.call_req            = c;
      bus.ret_req             = r;
      bus.jump_req            = j;
      bus.instruction_address = pc;
      bus.target_address      = tgt;
      #1;
   endtask

   task automatic tick;
      @(posedge CLK);
      #1;
   endtask

   task automatic idle;
      drive(1'b0, 1'b0, 1'b0, 5'd0, 5'd0);
   endtask

   task automatic do_call(input logic [4:0] pc, input logic [4:0] tgt);
      drive(1'b1, 1'b0, 1'b0, pc, tgt);
      tick;
   endtask

   initial begin
      RST = 1'b1;
      idle;
      // Reset held for two cycles
      chk("rst_jc", {3'b0, bus.jump_code}, 8'd0);
      tick;
      chk("rst_jc2", {3'b0, bus.jump_code}, 8'd0);
      tick;
      RST = 1'b0;
      idle;
      chk("idle_jc", {3'b0, bus.jump_code}, 8'd3);
      chk("idle_cnt", {5'b0, bus.stack_count}, 8'd0);
      chk("idle_fault", {7'b0, bus.fault}, 8'd0);
      chk("idle_cause", {6'b0, bus.fault_cause}, 8'd0);
      chk("idle_ra", {3'b0, bus.return_address}, 8'd0);

      // Single call / return
      drive(1'b1, 1'b0, 1'b0, 5'd5, 5'd20);
      chk("call_jc", {3'b0, bus.jump_code}, 8'd1);
      chk("call_ja", {3'b0, bus.jump_address}, 8'd20);
      tick;
      idle;
      chk("call_cnt", {5'b0, bus.stack_count}, 8'd1);
      chk("call_ra", {3'b0, bus.return_address}, 8'd6);
      drive(1'b0, 1'b1, 1'b0, 5'd20, 5'd0);
      chk("ret_jc", {3'b0, bus.jump_code}, 8'd2);
      chk("ret_ra", {3'b0, bus.return_address}, 8'd6);
      tick;
      idle;
      chk("ret_cnt", {5'b0, bus.stack_count}, 8'd0);
      chk("empty_ra", {3'b0, bus.return_address}, 8'd0);

      // Nested calls, popped in reverse order
      do_call(5'd1, 5'd8);
      do_call(5'd10, 5'd8);
      do_call(5'd11, 5'd8);
      do_call(5'd12, 5'd8);
      idle;
      chk("nest_cnt", {5'b0, bus.stack_count}, 8'd4);
      drive(1'b0, 1'b1, 1'b0, 5'd8, 5'd0);
      chk("pop1_jc", {3'b0, bus.jump_code}, 8'd2);
      chk("pop1_ra", {3'b0, bus.return_address}, 8'd13);
      tick;
      chk("pop2_ra", {3'b0, bus.return_address}, 8'd12);
      tick;
      chk("pop3_ra", {3'b0, bus.return_address}, 8'd11);
      tick;
      chk("pop4_ra", {3'b0, bus.return_address}, 8'd2);
      chk("pop4_cnt", {5'b0, bus.stack_count}, 8'd1);
      tick;
      idle;
      chk("pop_cnt", {5'b0, bus.stack_count}, 8'd0);

      // Overflow on the fifth call
      do_call(5'd1, 5'd8);
      do_call(5'd10, 5'd8);
      do_call(5'd11, 5'd8);
      do_call(5'd12, 5'd8);
      drive(1'b1, 1'b0, 1'b0, 5'd20, 5'd9);
      chk("ovf_jc", {3'b0, bus.jump_code}, 8'd0);
      chk("ovf_ja", {3'b0, bus.jump_address}, 8'd9);
      chk("ovf_pre_flt", {7'b0, bus.fault}, 8'd0);
      tick;
      idle;
      chk("ovf_fault", {7'b0, bus.fault}, 8'd1);
      chk("ovf_cause", {6'b0, bus.fault_cause}, 8'd1);
      chk("ovf_cnt", {5'b0, bus.stack_count}, 8'd0);
      chk("ovf_idle_jc", {3'b0, bus.jump_code}, 8'd0);
      tick;
      chk("ovf_hold", {7'b0, bus.fault}, 8'd1);

      // Reset clears the fault
      RST = 1'b1;
      tick;
      RST = 1'b0;
      idle;
      chk("clr_fault", {7'b0, bus.fault}, 8'd0);
      chk("clr_cause", {6'b0, bus.fault_cause}, 8'd0);

      // Underflow, then requests are ignored
      drive(1'b0, 1'b1, 1'b0, 5'd4, 5'd0);
      chk("unf_jc", {3'b0, bus.jump_code}, 8'd0);
      tick;
      drive(1'b1, 1'b0, 1'b0, 5'd4, 5'd6);
      chk("unf_fault", {7'b0, bus.fault}, 8'd1);
      chk("unf_cause", {6'b0, bus.fault_cause}, 8'd2);
      chk("flt_call_jc", {3'b0, bus.jump_code}, 8'd0);
      tick;
      drive(1'b0, 1'b0, 1'b1, 5'd4, 5'd6);
      chk("flt_jump_jc", {3'b0, bus.jump_code}, 8'd0);
      chk("flt_cnt", {5'b0, bus.stack_count}, 8'd0);
      tick;
      chk("flt_sticky", {7'b0, bus.fault}, 8'd1);
      RST = 1'b1;
      tick;
      RST = 1'b0;
      idle;

      // Priority: RET beats CALL, CALL beats JUMP
      do_call(5'd6, 5'd3);
      idle;
      chk("pri_ra", {3'b0, bus.return_address}, 8'd7);
      drive(1'b1, 1'b1, 1'b0, 5'd14, 5'd30);
      chk("pri_rc_jc", {3'b0, bus.jump_code}, 8'd2);
      chk("pri_rc_ra", {3'b0, bus.return_address}, 8'd7);
      tick;
      idle;
      chk("pri_rc_cnt", {5'b0, bus.stack_count}, 8'd0);
      drive(1'b1, 1'b0, 1'b1, 5'd3, 5'd25);
      chk("pri_cj_jc", {3'b0, bus.jump_code}, 8'd1);
      chk("pri_cj_ja", {3'b0, bus.jump_address}, 8'd25);
      tick;
      idle;
      chk("pri_cj_cnt", {5'b0, bus.stack_count}, 8'd1);
      chk("pri_cj_ra", {3'b0, bus.return_address}, 8'd4);

      // Plain jump leaves the stack alone
      drive(1'b0, 1'b0, 1'b1, 5'd9, 5'd17);
      chk("jmp_jc", {3'b0, bus.jump_code}, 8'd1);
      chk("jmp_ja", {3'b0, bus.jump_address}, 8'd17);
      tick;
      idle;
      chk("jmp_cnt", {5'b0, bus.stack_count}, 8'd1);
      chk("jmp_ra", {3'b0, bus.return_address}, 8'd4);
      drive(1'b0, 1'b1, 1'b0, 5'd17, 5'd0);
      tick;
      idle;

      // Return address wraps from 31 to 0
      drive(1'b1, 1'b0, 1'b0, 5'd31, 5'd0);
      chk("wrap_jc", {3'b0, bus.jump_code}, 8'd1);
      chk("wrap_ja", {3'b0, bus.jump_address}, 8'd0);
      tick;
      idle;
      chk("wrap_cnt", {5'b0, bus.stack_count}, 8'd1);
      drive(1'b0, 1'b1, 1'b0, 5'd0, 5'd0);
      chk("wrap_ret_jc", {3'b0, bus.jump_code}, 8'd2);
      chk("wrap_ret_ra", {3'b0, bus.return_address}, 8'd0);
      tick;
      idle;
      chk("wrap_end_cnt", {5'b0, bus.stack_count}, 8'd0);

      // Reset in the middle of a nest
      do_call(5'd2, 5'd10);
      do_call(5'd3, 5'd10);
      do_call(5'd4, 5'd10);
      idle;
      chk("mid_cnt", {5'b0, bus.stack_count}, 8'd3);
      chk("mid_ra", {3'b0, bus.return_address}, 8'd5);
      RST = 1'b1;
      drive(1'b1, 1'b0, 1'b0, 5'd5, 5'd10);
      chk("mid_rst_jc", {3'b0, bus.jump_code}, 8'd0);
      tick;
      RST = 1'b0;
      idle;
      chk("mid_rst_cnt", {5'b0, bus.stack_count}, 8'd0);
      chk("mid_rst_flt", {7'b0, bus.fault}, 8'd0);
      chk("mid_rst_jc2", {3'b0, bus.jump_code}, 8'd3);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/call_return_ctrl.md
Name: call_return_ctrl

Overview:
- Control-flow sequencer that drives the program counter. It produces `jump_code`, `jump_address` and `return_address` for the PC each cycle.
- It owns a hardware return-address stack:
  - CALL pushes PC+1 and jumps to the target.
  - RET pops the top entry and returns to it.
  - JUMP is a plain branch.
- Stack overflow or underflow puts the block into a sticky fault state, which holds the PC in RESET.

Parameters:
- INSTR_ADDR_SIZE, 5, width of every instruction address.
- STACK_DEPTH, 4, number of return-address entries (must be ≥1).
- CNT_W, $clog2(STACK_DEPTH+1), width of the occupancy count.

Ports:
- CLK  input  1  rising-edge clock.
- RST  input  1  synchronous reset, active-high.
- instruction_address  input  INSTR_ADDR_SIZE  current PC value.
- call_req  input  1  request: push return address and jump to `target_address`.
- ret_req  input  1  request: pop and return.
- jump_req  input  1  request: plain jump to `target_address`.
- target_address  input  INSTR_ADDR_SIZE  destination for CALL or JUMP.
- jump_code  output  5  PC opcode. Encodings: 0 RESET, 1 JUMP, 2 RET, 3 DEFAULT (increment). Bits [4:2] are always 0.
- jump_address  output  INSTR_ADDR_SIZE  jump destination.
- return_address  output  INSTR_ADDR_SIZE  top-of-stack entry.
- stack_count  output  CNT_W  current number of stacked entries.
- fault  output  1  sticky; 1 while in the FAULT state.
- fault_cause  output  2  01 = overflow, 10 = underflow, 00 = none. Latched on entry to FAULT.

Behaviour:
- Clock and reset:
  - One clock domain.
  - All state updates on the rising edge of CLK.
- Reset (RST=1):
  - `jump_code` is 0 (RESET) combinationally during the reset cycle.
  - At the edge: state←RUN, `stack_count`←0, `fault`←0, `fault_cause`←00.
  - Stack RAM contents are don't-care.
- States: RUN, FAULT. Only RST leaves FAULT.
- RUN, request priority: ret_req > call_req > jump_req. Lower-priority requests asserted in the same cycle are ignored with no side effects.
- RET, `stack_count` > 0:
  - `jump_code`=2.
  - At the edge: `stack_count` decrements.
- RET, `stack_count` == 0 (underflow):
  - `jump_code`=0 in that cycle.
  - At the edge: state←FAULT, `fault_cause`←10.
- CALL, `stack_count` < STACK_DEPTH:
  - `jump_code`=1, `jump_address`=`target_address`.
  - At the edge: push (`instruction_address`+1) mod 2^INSTR_ADDR_SIZE, `stack_count` increments.
- CALL, `stack_count` == STACK_DEPTH (overflow):
  - No push.
  - `jump_code`=0 in that cycle.
  - At the edge: state←FAULT, `fault_cause`←01.
- JUMP:
  - `jump_code`=1, `jump_address`=`target_address`.
  - Stack unchanged.
- No request: `jump_code`=3.
- FAULT:
  - `jump_code`=0 every cycle.
  - All requests ignored.
  - `stack_count` forced to 0 at the first FAULT edge.
  - `fault`=1.
- Output timing:
  - `jump_code` and `jump_address` are combinational from the current requests and registered state. Zero-cycle latency, so the PC acts on the request at the same edge.
  - `return_address` = stack[`stack_count`-1] (registered storage) when `stack_count` > 0, else 0.
  - `jump_address` = `target_address` whenever `jump_code` is not 1 as well (pass-through).
- Stack storage:
  - LIFO; write index is `stack_count`.
  - A push and a pop never occur in the same cycle, because of the request priority.
- Wrap-around: a return address computed from `instruction_address` = all-ones wraps to 0.

Test Plan:
- RST=1 for 2 cycles → `jump_code`=0. After release with no requests → `jump_code`=3, `stack_count`=0, `fault`=0.
- PC=5, call_req, `target_address`=20 → `jump_code`=1, `jump_address`=20. Next cycle `stack_count`=1, `return_address`=6. Then ret_req → `jump_code`=2, `return_address`=6, after the edge `stack_count`=0.
- Nested calls at PC=1,10,11,12 (STACK_DEPTH=4) → returns pop 13, 12, 11, 2 in order. A fifth call at `stack_count`=4 → `jump_code`=0, `fault`=1, `fault_cause`=01, `stack_count`=0.
- ret_req at `stack_count`=0 → `jump_code`=0, `fault`=1, `fault_cause`=10. Subsequent call/jump requests → `jump_code` stays 0 until RST.
- call_req+ret_req together with `stack_count`=1 (top=7) → `jump_code`=2, `return_address`=7, `stack_count`→0, no push. jump_req+call_req with PC=3 → CALL wins, pushes 4.
- PC=31, call_req, target 0 → pushed 0; ret returns 0. RST asserted mid-nest with `stack_count`=3 → next cycle `stack_count`=0, `fault`=0.
